// File: rtl/ulpi_phy_frontend.sv
// ULPI PHY front end: lock-qualified reset sequencer, registered pad paths and DIR turnaround.
// Define ULPI_FRONTEND_STATUS_EN to build the saturating turnaround / lock-loss counters.
module ulpi_phy_frontend #(
  parameter int LOCK_WAIT       = 1024,
  parameter int PHY_RST_CYCLES  = 64,
  parameter int PHY_WAKE_CYCLES = 4096,
  parameter int CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pll_locked_i,
  output logic             phy_rst_o,
  output logic             core_rst_o,
  input  logic [7:0]       ulpi_data_i,
  output logic [7:0]       ulpi_data_o,
  output logic             ulpi_data_oe_o,
  input  logic             ulpi_dir_i,
  input  logic             ulpi_nxt_i,
  output logic             ulpi_stp_o,
  output logic [7:0]       core_data_o,
  output logic             core_dir_o,
  output logic             core_nxt_o,
  output logic             core_turn_o,
  input  logic [7:0]       core_data_i,
  input  logic             core_stp_i,
  output logic [CNT_W-1:0] stat_turn_o,
  output logic [CNT_W-1:0] stat_unlock_o
);

  typedef enum logic [2:0] {
    S_RESET, S_WAIT_LOCK, S_PHY_RST, S_PHY_WAKE, S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(PHY_WAKE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phy_rst_q, phy_rst_d, core_rst_q, core_rst_d;
  logic             stp_q, stp_d;
  logic [7:0]       dout_q, dout_d, rx_data_q, rx_data_d;
  logic             dir_q, dir_d, nxt_q, nxt_d, turn_q, turn_d;
  logic             run_q, run_d;

  // Lock loss is tested before any exit so it wins over a same-cycle state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      S_RESET: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
      S_WAIT_LOCK: begin
        if (!pll_locked_i) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_PHY_RST;
          cnt_d   = '0;
        end
      end
      S_PHY_RST: begin
        if (!pll_locked_i) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = S_PHY_WAKE;
          cnt_d   = '0;
        end
      end
      S_PHY_WAKE: begin
        if (!pll_locked_i) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == WAKE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!pll_locked_i) state_d = S_WAIT_LOCK;
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs follow the next state so they change on the same edge as the sequencer.
  always_comb begin
    run_q      = (state_q == S_RUN);
    run_d      = (state_d == S_RUN);
    phy_rst_d  = (state_d == S_PHY_RST);
    core_rst_d = !run_d;
    stp_d      = run_d ? core_stp_i : 1'b1;
    dout_d     = run_d ? core_data_i : 8'h00;
    rx_data_d  = ulpi_data_i;
    dir_d      = ulpi_dir_i;
    nxt_d      = ulpi_nxt_i;
    turn_d     = ulpi_dir_i ^ dir_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      phy_rst_q  <= 1'b0;
      core_rst_q <= 1'b1;
      stp_q      <= 1'b1;
      dout_q     <= 8'h00;
      rx_data_q  <= 8'h00;
      dir_q      <= 1'b0;
      nxt_q      <= 1'b0;
      turn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phy_rst_q  <= phy_rst_d;
      core_rst_q <= core_rst_d;
      stp_q      <= stp_d;
      dout_q     <= dout_d;
      rx_data_q  <= rx_data_d;
      dir_q      <= dir_d;
      nxt_q      <= nxt_d;
      turn_q     <= turn_d;
    end
  end

  assign phy_rst_o      = phy_rst_q;
  assign core_rst_o     = core_rst_q;
  assign ulpi_stp_o     = stp_q;
  assign ulpi_data_o    = dout_q;
  // Release the bus the instant DIR rises; re-drive only once the registered DIR is low too.
  assign ulpi_data_oe_o = run_q & !ulpi_dir_i & !dir_q;
  assign core_data_o    = rx_data_q;
  assign core_dir_o     = dir_q;
  assign core_nxt_o     = nxt_q;
  assign core_turn_o    = turn_q;

`ifdef ULPI_FRONTEND_STATUS_EN
  logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d, unlock_cnt_q, unlock_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    turn_cnt_d   = sat_inc(turn_cnt_q, run_q & (ulpi_dir_i ^ dir_q));
    unlock_cnt_d = sat_inc(unlock_cnt_q, run_q & !pll_locked_i);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      turn_cnt_q   <= '0;
      unlock_cnt_q <= '0;
    end else begin
      turn_cnt_q   <= turn_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
    end
  end

  assign stat_turn_o   = turn_cnt_q;
  assign stat_unlock_o = unlock_cnt_q;
`else
  assign stat_turn_o   = '0;
  assign stat_unlock_o = '0;
`endif

endmodule

// File: tb/tb_ulpi_phy_frontend.sv
// Randomized bench for ulpi_phy_frontend against a cycle-count based behavioural model.
module tb_ulpi_phy_frontend;
  localparam int LW     = 4;
  localparam int PR     = 3;
  localparam int PW     = 5;
  localparam int CW     = 16;
  localparam int PHY_T0 = 1 + LW;
  localparam int PHY_T1 = 1 + LW + PR;
  localparam int RUN_T  = 1 + LW + PR + PW;
  localparam int SAT    = (1 << CW) - 1;
`ifdef ULPI_FRONTEND_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          pll_locked_i = 1'b1;
  logic          phy_rst_o, core_rst_o;
  logic [7:0]    ulpi_data_i = 8'h00;
  logic [7:0]    ulpi_data_o;
  logic          ulpi_data_oe_o;
  logic          ulpi_dir_i = 1'b0;
  logic          ulpi_nxt_i = 1'b0;
  logic          ulpi_stp_o;
  logic [7:0]    core_data_o;
  logic          core_dir_o, core_nxt_o, core_turn_o;
  logic [7:0]    core_data_i = 8'h00;
  logic          core_stp_i = 1'b0;
  logic [CW-1:0] stat_turn_o, stat_unlock_o;

  ulpi_phy_frontend #(
    .LOCK_WAIT(LW), .PHY_RST_CYCLES(PR), .PHY_WAKE_CYCLES(PW), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pll_locked_i(pll_locked_i),
    .phy_rst_o(phy_rst_o), .core_rst_o(core_rst_o),
    .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o), .ulpi_data_oe_o(ulpi_data_oe_o),
    .ulpi_dir_i(ulpi_dir_i), .ulpi_nxt_i(ulpi_nxt_i), .ulpi_stp_o(ulpi_stp_o),
    .core_data_o(core_data_o), .core_dir_o(core_dir_o), .core_nxt_o(core_nxt_o),
    .core_turn_o(core_turn_o), .core_data_i(core_data_i), .core_stp_i(core_stp_i),
    .stat_turn_o(stat_turn_o), .stat_unlock_o(stat_unlock_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_t counts consecutive lock-good edges since the sequence (re)started;
  // every output phase is a plain threshold on that count.
  int         m_t = 0;
  int         m_tcnt = 0;
  int         m_ucnt = 0;
  logic [7:0] m_rx = 8'h00, m_tx = 8'h00;
  logic       m_dir = 1'b0, m_nxt = 1'b0, m_turn = 1'b0, m_stp = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit run_before, run_after;
    if (!rst_i) begin
      m_t = 0; m_tcnt = 0; m_ucnt = 0;
      m_rx = 8'h00; m_tx = 8'h00;
      m_dir = 1'b0; m_nxt = 1'b0; m_turn = 1'b0; m_stp = 1'b1;
    end else begin
      run_before = (m_t >= RUN_T);
      if (run_before && (ulpi_dir_i != m_dir) && m_tcnt < SAT) m_tcnt++;
      if (run_before && !pll_locked_i && m_ucnt < SAT) m_ucnt++;
      if (m_t == 0 || !pll_locked_i) m_t = 1;
      else if (m_t < RUN_T) m_t++;
      run_after = (m_t >= RUN_T);
      m_turn = ulpi_dir_i ^ m_dir;
      m_dir  = ulpi_dir_i;
      m_nxt  = ulpi_nxt_i;
      m_rx   = ulpi_data_i;
      m_stp  = run_after ? core_stp_i : 1'b1;
      m_tx   = run_after ? core_data_i : 8'h00;
    end
  endtask

  task automatic compare_all();
    check("phy_rst",   32'(phy_rst_o),      32'(m_t >= PHY_T0 && m_t < PHY_T1));
    check("core_rst",  32'(core_rst_o),     32'(m_t < RUN_T));
    check("stp",       32'(ulpi_stp_o),     32'(m_stp));
    check("data_o",    32'(ulpi_data_o),    32'(m_tx));
    check("oe",        32'(ulpi_data_oe_o), 32'((m_t >= RUN_T) && !ulpi_dir_i && !m_dir));
    check("rx_data",   32'(core_data_o),    32'(m_rx));
    check("rx_dir",    32'(core_dir_o),     32'(m_dir));
    check("rx_nxt",    32'(core_nxt_o),     32'(m_nxt));
    check("turn",      32'(core_turn_o),    32'(m_turn));
    check("stat_turn", 32'(stat_turn_o),    STAT_EN ? 32'(m_tcnt) : 32'(0));
    check("stat_unlk", 32'(stat_unlock_o),  STAT_EN ? 32'(m_ucnt) : 32'(0));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic rand_inputs();
    ulpi_data_i = 8'($urandom);
    ulpi_nxt_i  = 1'($urandom);
    core_data_i = 8'($urandom);
    core_stp_i  = 1'($urandom);
  endtask

  initial begin
    // Reset held
    for (int i = 0; i < 3; i++) begin rand_inputs(); tick(); end
    rst_i = 1'b1;

    // Start-up with lock high, DIR idle low
    for (int k = 1; k <= 16; k++) begin
      rand_inputs();
      tick();
      if (k == 4)  check("start_phy_pre",   32'(phy_rst_o),  32'(0));
      if (k == 5)  check("start_phy_on",    32'(phy_rst_o),  32'(1));
      if (k == 7)  check("start_phy_last",  32'(phy_rst_o),  32'(1));
      if (k == 8)  check("start_phy_off",   32'(phy_rst_o),  32'(0));
      if (k == 12) check("start_core_held", 32'(core_rst_o), 32'(1));
      if (k == 13) check("start_core_rel",  32'(core_rst_o), 32'(0));
    end

    // Turnaround in RUN
    core_data_i = 8'h40; core_stp_i = 1'b0;
    tick();
    check("tx_data_40", 32'(ulpi_data_o), 32'h40);
    ulpi_dir_i = 1'b1;
    #1 check("oe_release", 32'(ulpi_data_oe_o), 32'(0));
    tick();
    check("turn_rise", 32'(core_turn_o), 32'(1));
    ulpi_dir_i = 1'b0;
    #1 check("oe_hold", 32'(ulpi_data_oe_o), 32'(0));
    tick();
    check("turn_fall", 32'(core_turn_o), 32'(1));
    check("oe_redrive", 32'(ulpi_data_oe_o), 32'(1));
    check("stat_turn_2", 32'(stat_turn_o), STAT_EN ? 32'(2) : 32'(0));

    // Receive
    ulpi_data_i = 8'h5A; ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b1;
    tick();
    check("rx_5a",  32'(core_data_o), 32'h5A);
    check("rx_dir1", 32'(core_dir_o), 32'(1));
    check("rx_nxt1", 32'(core_nxt_o), 32'(1));
    ulpi_dir_i = 1'b0;
    tick();

    // Random traffic in RUN
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      if ($urandom_range(3) == 0) ulpi_dir_i = ~ulpi_dir_i;
      tick();
    end

    // One-cycle lock loss in RUN
    ulpi_dir_i = 1'b0;
    tick(); tick();
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    check("unlock_core_rst", 32'(core_rst_o),     32'(1));
    check("unlock_stp",      32'(ulpi_stp_o),     32'(1));
    check("unlock_oe",       32'(ulpi_data_oe_o), 32'(0));
    check("unlock_cnt_1",    32'(stat_unlock_o),  STAT_EN ? 32'(1) : 32'(0));
    for (int j = 1; j <= 12; j++) begin
      rand_inputs();
      tick();
      if (j == 3) check("reseq_phy_pre", 32'(phy_rst_o), 32'(0));
      if (j == 4) check("reseq_phy_on",  32'(phy_rst_o), 32'(1));
    end

    // Random lock glitches mixed with DIR traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      pll_locked_i = ($urandom_range(39) != 0);
      if ($urandom_range(2) == 0) ulpi_dir_i = ~ulpi_dir_i;
      tick();
    end

    // Reset taken during PHY wake
    pll_locked_i = 1'b1; ulpi_dir_i = 1'b0;
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin rand_inputs(); tick(); end
    rst_i = 1'b0;
    #1;
    check("async_phy",      32'(phy_rst_o),      32'(0));
    check("async_core_rst", 32'(core_rst_o),     32'(1));
    check("async_stp",      32'(ulpi_stp_o),     32'(1));
    check("async_oe",       32'(ulpi_data_oe_o), 32'(0));
    check("async_turn_cnt", 32'(stat_turn_o),    32'(0));
    tick(); tick();
    rst_i = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      rand_inputs();
      tick();
      if (k == 4) check("rerst_phy_pre", 32'(phy_rst_o), 32'(0));
      if (k == 5) check("rerst_phy_on",  32'(phy_rst_o), 32'(1));
    end

    // Saturation: one DIR edge per clock in RUN
    for (int i = 0; i < 70000; i++) begin
      ulpi_dir_i = ~ulpi_dir_i;
      tick();
    end
    check("stat_turn_sat", 32'(stat_turn_o), STAT_EN ? 32'hFFFF : 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
